i2s_codec_master: RTL and testbench

I2S_CODEC_MASTER -- requirements
Module: i2s_codec_master

---
 rtl/i2s_codec_master.sv | 142 ++++++++++++++
 tb/tb_i2s_codec_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_codec_master.sv
// I2S master for a codec port: generates BCLK/LRCK, serialises one stereo pair per
// 64-bit frame on adcdat and deserialises the returning frame from dacdat.
module i2s_codec_master #(
   parameter int DATA_WIDTH = 24,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] adc_left_data,
   input  logic [DATA_WIDTH-1:0] adc_right_data,
   input  logic                  adc_valid,
   output logic                  adc_ready,
   output logic [DATA_WIDTH-1:0] dac_left_data,
   output logic [DATA_WIDTH-1:0] dac_right_data,
   output logic                  dac_valid,
   output logic                  adc_underrun,
   output logic                  bclk,
   output logic                  lrck,
   output logic                  adcdat,
   input  logic                  dacdat
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] left;
      logic [DATA_WIDTH-1:0] right;
   } pair_t;

   localparam logic [7:0] HP_TC  = 8'(BCLK_DIV - 1);
   localparam logic [4:0] P_LAST = 5'(DATA_WIDTH);

   logic [7:0]            hp_cnt;
   logic [5:0]            bit_cnt;
   logic [5:0]            bit_nxt;
   logic [4:0]            slot_cur;
   logic                  tc;
   logic                  fall_ev;
   logic                  rise_ev;
   logic                  frame_start;
   logic                  hs;
   logic                  rx_slot;

   pair_t                 pend;
   logic                  pend_full;
   logic [DATA_WIDTH-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] tx_right;
   logic [DATA_WIDTH-1:0] rx_left;
   logic [DATA_WIDTH-1:0] rx_right;
   logic                  frame_seen;

   assign tc          = (hp_cnt == HP_TC);
   assign fall_ev     = tc & bclk;
   assign rise_ev     = tc & ~bclk;
   assign bit_nxt     = bit_cnt + 6'd1;
   assign slot_cur    = bit_cnt[4:0];
   assign frame_start = fall_ev & (bit_cnt == 6'd63);
   assign adc_ready   = ~pend_full;
   assign hs          = adc_valid & adc_ready;
   assign rx_slot     = rise_ev & (slot_cur != 5'd0) & (slot_cur <= P_LAST);

   // Bit clock: toggle on every terminal count of the half-period counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hp_cnt <= '0;
         bclk   <= 1'b0;
      end else begin
         hp_cnt <= tc ? 8'd0 : hp_cnt + 8'd1;
         if (tc) bclk <= ~bclk;
      end
   end

   // One-deep pending buffer; a frame start with a full buffer wins over a handshake,
   // and the two can never coincide because adc_ready is low while full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend      <= '0;
         pend_full <= 1'b0;
      end else if (frame_start && pend_full) begin
         pend_full <= 1'b0;
      end else if (hs) begin
         pend      <= '{left: adc_left_data, right: adc_right_data};
         pend_full <= 1'b1;
      end
   end

   // Transmit: slot 0 of each channel reloads the shifter and emits the delay bit;
   // later slots shift in zeros, so positions past DATA_WIDTH come out as 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt      <= 6'd63;
         lrck         <= 1'b0;
         adcdat       <= 1'b0;
         tx_sr        <= '0;
         tx_right     <= '0;
         adc_underrun <= 1'b0;
      end else begin
         adc_underrun <= frame_start & ~pend_full;
         if (frame_start) tx_right <= pend_full ? pend.right : '0;
         if (fall_ev) begin
            bit_cnt <= bit_nxt;
            lrck    <= bit_nxt[5];
            if (bit_nxt[4:0] == 5'd0) begin
               adcdat <= 1'b0;
               if (frame_start) tx_sr <= pend_full ? pend.left : '0;
               else             tx_sr <= tx_right;
            end else begin
               adcdat <= tx_sr[DATA_WIDTH-1];
               tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // Receive: after DATA_WIDTH shifts the register holds the whole word, MSB first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_left  <= '0;
         rx_right <= '0;
      end else if (rx_slot) begin
         if (lrck) rx_right <= {rx_right[DATA_WIDTH-2:0], dacdat};
         else      rx_left  <= {rx_left[DATA_WIDTH-2:0], dacdat};
      end
   end

   // The first frame start after reset closes no real frame, so it is not reported.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dac_left_data  <= '0;
         dac_right_data <= '0;
         dac_valid      <= 1'b0;
         frame_seen     <= 1'b0;
      end else begin
         dac_valid <= 1'b0;
         if (frame_start) begin
            dac_left_data  <= rx_left;
            dac_right_data <= rx_right;
            dac_valid      <= frame_seen;
            frame_seen     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_codec_master.sv
// Bench for i2s_codec_master: a time-based frame model predicts every serial output,
// with adcdat looped back to dacdat so received pairs can be checked end to end.
module tb_i2s_codec_master;

   localparam int DW = 24;
   localparam int BD = 4;
   localparam int P  = 2 * BD;
   localparam int FR = 64 * P;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] adc_left_data = '0;
   logic [DW-1:0] adc_right_data = '0;
   logic          adc_valid = 1'b0;
   logic          adc_ready;
   logic [DW-1:0] dac_left_data;
   logic [DW-1:0] dac_right_data;
   logic          dac_valid;
   logic          adc_underrun;
   logic          bclk;
   logic          lrck;
   logic          adcdat;
   logic          dacdat = 1'b0;

   int t;
   int n_pass;
   int n_total;
   logic [DW-1:0] dl [0:2047];
   logic [DW-1:0] dr [0:2047];

   i2s_codec_master #(.DATA_WIDTH(DW), .BCLK_DIV(BD)) dut (
      .clk(clk), .reset_n(reset_n),
      .adc_left_data(adc_left_data), .adc_right_data(adc_right_data),
      .adc_valid(adc_valid), .adc_ready(adc_ready),
      .dac_left_data(dac_left_data), .dac_right_data(dac_right_data),
      .dac_valid(dac_valid), .adc_underrun(adc_underrun),
      .bclk(bclk), .lrck(lrck), .adcdat(adcdat), .dacdat(dacdat)
   );

   always #5 clk = ~clk;

   // t = number of rising clk edges since reset release
   always @(posedge clk or negedge reset_n)
      if (!reset_n) t <= 0;
      else          t <= t + 1;

   always @(posedge clk) dacdat <= adcdat;

   function automatic int m_cnt(int tt);
      if (tt < P) return 63;
      return ((tt / P) - 1) % 64;
   endfunction

   function automatic logic m_bclk(int tt);
      return ((tt / BD) % 2) == 1;
   endfunction

   function automatic logic m_lrck(int tt);
      if (tt < P) return 1'b0;
      return m_cnt(tt) >= 32;
   endfunction

   function automatic logic is_fs(int tt);
      return (tt >= P) && (((tt - P) % FR) == 0);
   endfunction

   function automatic int next_fs(int h);
      if (h < P) return P;
      return P + ((h - P) / FR + 1) * FR;
   endfunction

   function automatic logic m_bit(int tt, logic [DW-1:0] l, logic [DW-1:0] r);
      int c;
      int p;
      logic [DW-1:0] w;
      if (tt < P) return 1'b0;
      c = m_cnt(tt);
      p = c % 32;
      w = (c >= 32) ? r : l;
      if (p < 1 || p > DW) return 1'b0;
      w = w >> (DW - p);
      return w[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      adc_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if ({bclk, lrck, adcdat, adc_ready, dac_valid, adc_underrun} !== 6'b000100)
         $display("FAIL reset_ctl: got %b want 000100",
                  {bclk, lrck, adcdat, adc_ready, dac_valid, adc_underrun});
      else n_pass++;
      n_total++;
      if (dac_left_data !== '0) $display("FAIL reset_dac_left: got %h want 0", dac_left_data);
      else n_pass++;
      n_total++;
      if (dac_right_data !== '0) $display("FAIL reset_dac_right: got %h want 0", dac_right_data);
      else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_timing();
      apply_reset();
      while (t < 1100) begin
         tick();
         n_total++;
         if ({bclk, lrck} !== {m_bclk(t), m_lrck(t)})
            $display("FAIL timing t=%0d: bclk,lrck got %b%b want %b%b",
                     t, bclk, lrck, m_bclk(t), m_lrck(t));
         else n_pass++;
      end
   endtask

   task automatic test_tx_loopback();
      logic [DW-1:0] pl [4];
      logic [DW-1:0] pr [4];
      int hs_t [3];
      int f;
      logic exp_rdy;
      logic exp_u;
      logic exp_v;
      pl[0] = 24'hABCDEF; pr[0] = 24'h123456;
      pl[1] = 24'h800001; pr[1] = 24'h7FFFFF;
      pl[2] = DW'($urandom); pr[2] = DW'($urandom);
      pl[3] = '0; pr[3] = '0;
      hs_t[0] = 1; hs_t[1] = 100; hs_t[2] = 600;
      apply_reset();
      while (t < P + 3 * FR + 2) begin
         adc_valid      = 1'b0;
         adc_left_data  = DW'($urandom);
         adc_right_data = DW'($urandom);
         for (int k = 0; k < 3; k++)
            if (t + 1 == hs_t[k]) begin
               adc_valid = 1'b1; adc_left_data = pl[k]; adc_right_data = pr[k];
            end
         tick();
         exp_rdy = 1'b1;
         for (int k = 0; k < 3; k++)
            if (t >= hs_t[k] && t < next_fs(hs_t[k])) exp_rdy = 1'b0;
         n_total++;
         if (adc_ready !== exp_rdy)
            $display("FAIL tx_ready t=%0d: got %b want %b", t, adc_ready, exp_rdy);
         else n_pass++;
         if (t >= P) begin
            f = (t - P) / FR;
            n_total++;
            if (adcdat !== m_bit(t, pl[f], pr[f]))
               $display("FAIL tx_adcdat t=%0d: got %b want %b", t, adcdat, m_bit(t, pl[f], pr[f]));
            else n_pass++;
            exp_u = is_fs(t) && f >= 3;
            n_total++;
            if (adc_underrun !== exp_u)
               $display("FAIL tx_underrun t=%0d: got %b want %b", t, adc_underrun, exp_u);
            else n_pass++;
            exp_v = is_fs(t) && f >= 1;
            n_total++;
            if (dac_valid !== exp_v)
               $display("FAIL tx_dac_valid t=%0d: got %b want %b", t, dac_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
               n_total++;
               if ({dac_left_data, dac_right_data} !== {pl[f-1], pr[f-1]})
                  $display("FAIL loopback_pair t=%0d: got %h/%h want %h/%h",
                           t, dac_left_data, dac_right_data, pl[f-1], pr[f-1]);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_underrun();
      int n_under;
      logic exp_v;
      n_under = 0;
      apply_reset();
      while (t < P + 2 * FR + 4) begin
         adc_left_data  = DW'($urandom);
         adc_right_data = DW'($urandom);
         tick();
         if (adc_underrun === 1'b1) n_under++;
         n_total++;
         if ({adcdat, adc_ready} !== 2'b01)
            $display("FAIL idle_adcdat_ready t=%0d: got %b%b want 01", t, adcdat, adc_ready);
         else n_pass++;
         n_total++;
         if (adc_underrun !== is_fs(t))
            $display("FAIL idle_underrun t=%0d: got %b want %b", t, adc_underrun, is_fs(t));
         else n_pass++;
         exp_v = is_fs(t) && t > P;
         n_total++;
         if (dac_valid !== exp_v)
            $display("FAIL idle_dac_valid t=%0d: got %b want %b", t, dac_valid, exp_v);
         else n_pass++;
         if (exp_v) begin
            n_total++;
            if ({dac_left_data, dac_right_data} !== '0)
               $display("FAIL idle_dac_data t=%0d: got %h/%h want 0/0", t, dac_left_data, dac_right_data);
            else n_pass++;
         end
      end
      n_total++;
      if (n_under != 3) $display("FAIL underrun_count: got %0d want 3", n_under);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int f;
      int h;
      logic exp_v;
      apply_reset();
      while (t < P + 3 * FR + 4) begin
         adc_valid      = 1'b1;
         adc_left_data  = DW'($urandom);
         adc_right_data = DW'($urandom);
         dl[t+1] = adc_left_data;
         dr[t+1] = adc_right_data;
         tick();
         n_total++;
         if (adc_ready !== is_fs(t))
            $display("FAIL b2b_ready t=%0d: got %b want %b", t, adc_ready, is_fs(t));
         else n_pass++;
         n_total++;
         if (adc_underrun !== 1'b0)
            $display("FAIL b2b_underrun t=%0d: got %b want 0", t, adc_underrun);
         else n_pass++;
         if (t >= P) begin
            f = (t - P) / FR;
            h = (f == 0) ? 1 : P + (f - 1) * FR + 1;
            n_total++;
            if (adcdat !== m_bit(t, dl[h], dr[h]))
               $display("FAIL b2b_adcdat t=%0d: got %b want %b", t, adcdat, m_bit(t, dl[h], dr[h]));
            else n_pass++;
            exp_v = is_fs(t) && f >= 1;
            n_total++;
            if (dac_valid !== exp_v)
               $display("FAIL b2b_dac_valid t=%0d: got %b want %b", t, dac_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
               h = (f == 1) ? 1 : P + (f - 2) * FR + 1;
               n_total++;
               if ({dac_left_data, dac_right_data} !== {dl[h], dr[h]})
                  $display("FAIL b2b_pair t=%0d: got %h/%h want %h/%h",
                           t, dac_left_data, dac_right_data, dl[h], dr[h]);
               else n_pass++;
            end
         end
      end
      adc_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      logic exp_v;
      l = DW'($urandom) | 24'h800000;
      r = DW'($urandom) | 24'h800000;
      apply_reset();
      adc_valid = 1'b1; adc_left_data = l; adc_right_data = r;
      while (t < 300) begin
         tick();
         adc_valid = 1'b0;
         n_total++;
         if ({bclk, lrck, adcdat} !== {m_bclk(t), m_lrck(t), m_bit(t, l, r)})
            $display("FAIL pre_reset t=%0d: got %b%b%b want %b%b%b", t, bclk, lrck, adcdat,
                     m_bclk(t), m_lrck(t), m_bit(t, l, r));
         else n_pass++;
      end
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({bclk, lrck, adcdat, adc_ready, dac_valid, adc_underrun} !== 6'b000100)
         $display("FAIL async_reset_ctl: got %b want 000100",
                  {bclk, lrck, adcdat, adc_ready, dac_valid, adc_underrun});
      else n_pass++;
      n_total++;
      if ({dac_left_data, dac_right_data} !== '0)
         $display("FAIL async_reset_dac: got %h/%h want 0/0", dac_left_data, dac_right_data);
      else n_pass++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      while (t < P + FR + 2) begin
         tick();
         n_total++;
         if ({bclk, lrck, adcdat} !== {m_bclk(t), m_lrck(t), 1'b0})
            $display("FAIL post_reset t=%0d: got %b%b%b want %b%b0", t, bclk, lrck, adcdat,
                     m_bclk(t), m_lrck(t));
         else n_pass++;
         n_total++;
         if (adc_underrun !== is_fs(t))
            $display("FAIL post_reset_underrun t=%0d: got %b want %b", t, adc_underrun, is_fs(t));
         else n_pass++;
         exp_v = is_fs(t) && t > P;
         n_total++;
         if (dac_valid !== exp_v)
            $display("FAIL post_reset_dac_valid t=%0d: got %b want %b", t, dac_valid, exp_v);
         else n_pass++;
         if (exp_v) begin
            n_total++;
            if ({dac_left_data, dac_right_data} !== '0)
               $display("FAIL post_reset_dac_data t=%0d: got %h/%h want 0/0",
                        t, dac_left_data, dac_right_data);
            else n_pass++;
         end
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_timing();
      test_tx_loopback();
      test_underrun();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
